conv_post_quant: RTL and testbench

CONV_POST_QUANT -- requirements
Module: conv_post_quant

---
 rtl/conv_post_quant.sv | 105 ++++++++++
 tb/tb_conv_post_quant.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_post_quant.sv
// Convolution post-processing: bias add, round-half-up right shift, optional ReLU,
// signed saturation. Two-stage elastic pipeline. Define CONV_POST_RELU_EN to clamp negatives to 0.
module conv_post_quant #(
   parameter int IN_WIDTH    = 20,
   parameter int BIAS_WIDTH  = 16,
   parameter int OUT_WIDTH   = 8,
   parameter int SHIFT_WIDTH = 5,
   parameter int OUT_PIXELS  = 900
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic signed [IN_WIDTH-1:0]    din,
   input  logic                          din_valid,
   output logic                          din_ready,
   output logic signed [OUT_WIDTH-1:0]   dout,
   output logic                          dout_valid,
   input  logic                          dout_ready,
   output logic                          dout_last,
   input  logic signed [BIAS_WIDTH-1:0]  bias_config,
   input  logic [SHIFT_WIDTH-1:0]        shift_config,
   input  logic                          config_en
);

   localparam int SUM_W = ((IN_WIDTH > BIAS_WIDTH) ? IN_WIDTH : BIAS_WIDTH) + 1;
   localparam int RND_W = SUM_W + 1;
   localparam int SH_W  = $clog2(IN_WIDTH + 1);
   localparam int CNT_W = (OUT_PIXELS > 1) ? $clog2(OUT_PIXELS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_PIXELS - 1);
   localparam logic signed [RND_W-1:0] OUT_MAX = RND_W'(2 ** (OUT_WIDTH - 1) - 1);
   localparam logic signed [RND_W-1:0] OUT_MIN = ~OUT_MAX;

   logic signed [BIAS_WIDTH-1:0]  bias_q;
   logic [SHIFT_WIDTH-1:0]        shift_q;
   logic                          s1_valid_q;
   logic signed [SUM_W-1:0]       s1_sum_q, s1_sum_d;
   logic [SH_W-1:0]               s1_shift_q, s1_shift_d;
   logic                          dout_valid_q;
   logic signed [OUT_WIDTH-1:0]   dout_q, dout_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic                          s2_adv;
   logic signed [RND_W-1:0]       half, rnd, shifted, act;

   // S2 can take a new value when empty or when its current one leaves this cycle.
   assign s2_adv     = !dout_valid_q || dout_ready;
   assign din_ready  = !s1_valid_q || s2_adv;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign dout_last  = dout_valid_q && (cnt_q == CNT_LAST);

   always_comb begin
      s1_sum_d   = SUM_W'(din) + SUM_W'(bias_q);
      s1_shift_d = (int'(shift_q) > IN_WIDTH) ? SH_W'(IN_WIDTH) : SH_W'(shift_q);
   end

   always_comb begin
      half = '0;
      if (s1_shift_q != '0) half = RND_W'(1) << (s1_shift_q - SH_W'(1));
      rnd     = RND_W'(s1_sum_q) + half;
      shifted = rnd >>> s1_shift_q;
      act     = shifted;
`ifdef CONV_POST_RELU_EN
      if (shifted < 0) act = '0;
`endif
      if (act > OUT_MAX)      dout_d = OUT_WIDTH'(OUT_MAX);
      else if (act < OUT_MIN) dout_d = OUT_WIDTH'(OUT_MIN);
      else                    dout_d = OUT_WIDTH'(act);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (dout_valid_q && dout_ready) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bias_q       <= '0;
         shift_q      <= '0;
         s1_valid_q   <= 1'b0;
         s1_sum_q     <= '0;
         s1_shift_q   <= '0;
         dout_valid_q <= 1'b0;
         dout_q       <= '0;
         cnt_q        <= '0;
      end else begin
         // Sample captures the old bias/shift even when config_en fires on the same edge.
         if (config_en) begin
            bias_q  <= bias_config;
            shift_q <= shift_config;
         end
         if (din_ready) begin
            s1_valid_q <= din_valid;
            if (din_valid) begin
               s1_sum_q   <= s1_sum_d;
               s1_shift_q <= s1_shift_d;
            end
         end
         if (s2_adv) begin
            dout_valid_q <= s1_valid_q;
            if (s1_valid_q) dout_q <= dout_d;
         end
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_conv_post_quant.sv
// Bench for conv_post_quant: vector table, stall/frame/reset sequences, randomized traffic
// against an arithmetic reference model. Honours CONV_POST_RELU_EN like the design.
module tb_conv_post_quant;

   localparam int IW = 20;
   localparam int BW = 16;
   localparam int OW = 8;
   localparam int SW = 5;
   localparam int NP = 4;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic signed [IW-1:0]  din;
   logic                  din_valid;
   logic                  din_ready;
   logic signed [OW-1:0]  dout;
   logic                  dout_valid;
   logic                  dout_ready;
   logic                  dout_last;
   logic signed [BW-1:0]  bias_config;
   logic [SW-1:0]         shift_config;
   logic                  config_en;

   always #5 clk = ~clk;

   conv_post_quant #(
      .IN_WIDTH(IW), .BIAS_WIDTH(BW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW), .OUT_PIXELS(NP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
      .bias_config(bias_config), .shift_config(shift_config), .config_en(config_en)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   longint exp_q[$];
   longint bias_m;
   int     shift_m;
   int     out_cnt_m;
   int     lasts_seen;
   bit     stalled;
   longint held_dout;
   bit     held_last;
   bit     last_in_hs;

   typedef struct {
      longint d;
      longint b;
      int     s;
      longint e;
   } vec_t;
   vec_t vecs[9];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic longint ref_quant(input longint d, input longint b, input int s);
      longint v;
      int     sh;
      sh = (s > IW) ? IW : s;
      v  = d + b;
      if (sh > 0) v = v + (longint'(1) << (sh - 1));
      v = v >>> sh;
`ifdef CONV_POST_RELU_EN
      if (v < 0) v = 0;
`endif
      if (v > (longint'(1) << (OW - 1)) - 1) v = (longint'(1) << (OW - 1)) - 1;
      if (v < -(longint'(1) << (OW - 1)))    v = -(longint'(1) << (OW - 1));
      return v;
   endfunction

   // Called at a negedge after inputs are set; scores the handshakes of the coming posedge.
   task automatic cycle();
      bit     ih, oh;
      longint e;
      #1;
      last_in_hs = 1'b0;
      if (rst_n) begin
         ih = din_valid && din_ready;
         oh = dout_valid && dout_ready;
         if (stalled) begin
            check("stall_valid", dout_valid, 1);
            check("stall_dout", dout, held_dout);
            check("stall_last", dout_last, held_last);
         end
         if (oh) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("dout", dout, e);
               check("dout_last", dout_last, (out_cnt_m % NP) == NP - 1);
               out_cnt_m++;
            end
            if (dout_last) lasts_seen++;
         end
         stalled   = dout_valid && !dout_ready;
         held_dout = dout;
         held_last = dout_last;
         if (ih) exp_q.push_back(ref_quant(din, bias_config === bias_config ? bias_m : 0, shift_m));
         if (config_en) begin
            bias_m  = bias_config;
            shift_m = shift_config;
         end
         last_in_hs = ih;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      din_valid = 1'b0;
      config_en = 1'b0;
      #1;
      check("rst_dout_valid", dout_valid, 0);
      check("rst_dout", dout, 0);
      check("rst_dout_last", dout_last, 0);
      exp_q.delete();
      out_cnt_m = 0;
      bias_m    = 0;
      shift_m   = 0;
      stalled   = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      #1;
      check("rst_din_ready", din_ready, 1);
   endtask

   task automatic do_config(input longint b, input int s);
      din_valid    = 1'b0;
      bias_config  = BW'(b);
      shift_config = SW'(s);
      config_en    = 1'b1;
      cycle();
      config_en    = 1'b0;
   endtask

   task automatic drain();
      din_valid  = 1'b0;
      dout_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
      cycle();
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic stream_count(input int n);
      int idx;
      idx = 0;
      dout_ready = 1'b1;
      for (int c = 0; c < 4 * n && idx < n; c++) begin
         din_valid = 1'b1;
         din       = IW'(idx + 1);
         cycle();
         if (last_in_hs) idx++;
      end
      check("stream_accepted", idx, n);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      longint vals[4];
      int     idx;
      vec_t   v;

`ifdef CONV_POST_RELU_EN
      vecs[0] = '{100, 10, 2, 28};
      vecs[1] = '{524287, 0, 0, 127};
      vecs[2] = '{-524288, 0, 0, 0};
      vecs[3] = '{-6, 0, 2, 0};
      vecs[4] = '{1000, -24, 3, 122};
      vecs[5] = '{524287, 32767, 31, 1};
      vecs[6] = '{-300, 0, 1, 0};
      vecs[7] = '{5, 0, 1, 3};
      vecs[8] = '{-5, 0, 1, 0};
`else
      vecs[0] = '{100, 10, 2, 28};
      vecs[1] = '{524287, 0, 0, 127};
      vecs[2] = '{-524288, 0, 0, -128};
      vecs[3] = '{-6, 0, 2, -1};
      vecs[4] = '{1000, -24, 3, 122};
      vecs[5] = '{524287, 32767, 31, 1};
      vecs[6] = '{-300, 0, 1, -128};
      vecs[7] = '{5, 0, 1, 3};
      vecs[8] = '{-5, 0, 1, -2};
`endif

      rst_n        = 1'b0;
      din          = '0;
      din_valid    = 1'b0;
      dout_ready   = 1'b1;
      bias_config  = '0;
      shift_config = '0;
      config_en    = 1'b0;
      lasts_seen   = 0;
      @(negedge clk);
      do_reset();

      // Vector table: single sample, latency and value checked directly
      for (int i = 0; i < 9; i++) begin
         v = vecs[i];
         do_config(v.b, v.s);
         din        = IW'(v.d);
         din_valid  = 1'b1;
         dout_ready = 1'b1;
         cycle();
         check("vec_accept", last_in_hs, 1);
         din_valid = 1'b0;
         #1;
         check("vec_lat1_valid", dout_valid, 0);
         cycle();
         #1;
         check("vec_lat2_valid", dout_valid, 1);
         check("vec_dout", dout, v.e);
         cycle();
      end
      drain();

      // Backpressure: 1,2,3,4 with downstream stalled for 5 cycles
      do_reset();
      do_config(0, 0);
      vals[0] = 1; vals[1] = 2; vals[2] = 3; vals[3] = 4;
      idx = 0;
      dout_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         din_valid = (idx < 4);
         if (idx < 4) din = IW'(vals[idx]);
         cycle();
         if (last_in_hs) idx++;
      end
      check("stall_accepted", idx, 2);
      #1;
      check("stall_din_ready", din_ready, 0);
      dout_ready = 1'b1;
      for (int c = 0; c < 20 && idx < 4; c++) begin
         din_valid = 1'b1;
         din       = IW'(vals[idx]);
         cycle();
         if (last_in_hs) idx++;
      end
      check("stall_all_accepted", idx, 4);
      drain();

      // Frame marker: 8 samples give dout_last on outputs 4 and 8
      do_reset();
      lasts_seen = 0;
      stream_count(8);
      check("frame_outputs", out_cnt_m, 8);
      check("frame_lasts", lasts_seen, 2);

      // Reset while output pending, then a fresh frame
      dout_ready = 1'b0;
      din_valid  = 1'b1;
      din        = IW'(7);
      cycle();
      cycle();
      check("pre_reset_valid", dout_valid, 1);
      rst_n = 1'b0;
      #1;
      check("midreset_valid", dout_valid, 0);
      do_reset();
      lasts_seen = 0;
      stream_count(NP);
      check("post_reset_lasts", lasts_seen, 1);
      check("post_reset_outputs", out_cnt_m, NP);

      // Randomized traffic with occasional reconfiguration
      do_reset();
      for (int c = 0; c < 800; c++) begin
         din_valid    = ($urandom_range(0, 9) < 7);
         din          = IW'($urandom);
         dout_ready   = ($urandom_range(0, 9) < 6);
         config_en    = ($urandom_range(0, 19) == 0);
         bias_config  = BW'($urandom);
         shift_config = SW'($urandom_range(0, 31));
         cycle();
      end
      config_en = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
